// File: rtl/button_counter_pkg.sv
// Shared constants for the button counter: digit range, blank pattern and
// the seven-segment lookup table (active-high, bit6..bit0 = g,f,e,d,c,b,a).
package button_counter_pkg;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_ZERO_N = 7'b1000000;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

    // Active-low segment drive for a digit; anything outside 0..9 blanks.
    function automatic logic [6:0] seg_encode_n(input logic [3:0] digit);
        if (digit > DIGIT_MAX)
            return SEG_BLANK;
        return ~SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/button_counter_debounce_filter.sv
// Single-switch debouncer: the output level only follows the raw input once
// it has differed from the current level for DEBOUNCE_TIME consecutive cycles.
module debounce_filter #(
    parameter int DEBOUNCE_TIME = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_TIME);

    logic [CNT_W-1:0] r_Count;
    logic             r_State;

    // Count cycles of disagreement; accept the new level when the count hits the limit.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Count <= '0;
            r_State <= 1'b0;
        end else if (i_Switch == r_State) begin
            r_Count <= '0;
        end else if (r_Count == CNT_LIMIT - 1'b1) begin
            r_State <= i_Switch;
            r_Count <= '0;
        end else begin
            r_Count <= r_Count + 1'b1;
        end
    end

    assign o_Switch = r_State;

endmodule

// File: rtl/button_counter.sv
// Up/down decimal counter driven by two bouncing push-buttons, shown on an
// active-low seven-segment display.
// Optional macro BUTTON_COUNTER_INPUT_SYNC_EN adds a two-flop synchronizer on
// each switch ahead of the debouncers (2 extra cycles of latency).
module button_counter
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_TIME = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    output logic [6:0] o_Segments
);

    logic w_Raw_1;
    logic w_Raw_2;
    logic w_Stable_1;
    logic w_Stable_2;
    logic r_Stable_1_prev;
    logic r_Stable_2_prev;
    logic w_Inc;
    logic w_Dec;
    logic [3:0] r_Digit;

`ifdef BUTTON_COUNTER_INPUT_SYNC_EN
    logic [1:0] r_Sync_1;
    logic [1:0] r_Sync_2;

    // Two-flop synchronizers bring the asynchronous buttons into the clock domain.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Sync_1 <= 2'b00;
            r_Sync_2 <= 2'b00;
        end else begin
            r_Sync_1 <= {r_Sync_1[0], i_Switch_1};
            r_Sync_2 <= {r_Sync_2[0], i_Switch_2};
        end
    end

    assign w_Raw_1 = r_Sync_1[1];
    assign w_Raw_2 = r_Sync_2[1];
`else
    assign w_Raw_1 = i_Switch_1;
    assign w_Raw_2 = i_Switch_2;
`endif

    debounce_filter #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_debounce_1 (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (w_Raw_1),
        .o_Switch (w_Stable_1)
    );

    debounce_filter #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_debounce_2 (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (w_Raw_2),
        .o_Switch (w_Stable_2)
    );

    // Remember last debounced levels so only rising edges produce pulses.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Stable_1_prev <= 1'b0;
            r_Stable_2_prev <= 1'b0;
        end else begin
            r_Stable_1_prev <= w_Stable_1;
            r_Stable_2_prev <= w_Stable_2;
        end
    end

    assign w_Inc = w_Stable_1 & ~r_Stable_1_prev;
    assign w_Dec = w_Stable_2 & ~r_Stable_2_prev;

    // Decimal digit with wrap-around; increment wins when both pulses coincide.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Digit <= 4'd0;
        end else if (w_Inc) begin
            r_Digit <= (r_Digit >= DIGIT_MAX) ? 4'd0 : r_Digit + 4'd1;
        end else if (w_Dec) begin
            r_Digit <= (r_Digit == 4'd0) ? DIGIT_MAX : r_Digit - 4'd1;
        end
    end

    // Registered display decode.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            o_Segments <= SEG_ZERO_N;
        else
            o_Segments <= seg_encode_n(r_Digit);
    end

endmodule

// File: tb/tb_button_counter.sv
// Scoreboard bench for button_counter with DEBOUNCE_TIME = 50 and a 40 ns clock.
module tb_button_counter;

    localparam int DT = 50;

    logic       clk;
    logic       rst;
    logic       sw1;
    logic       sw2;
    logic [6:0] seg;

    typedef struct {
        logic [6:0] seg;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   chk_id = 0;

    // Active-low expected patterns, computed by hand from the g..a table.
    logic [6:0] seg_n [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    button_counter #(.DEBOUNCE_TIME(DT)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch_1 (sw1),
        .i_Switch_2 (sw2),
        .o_Segments (seg)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Monitor: pops one expectation per falling edge and compares with the display.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (seg !== e.seg) begin
                n_err++;
                $display("FAIL chk%0d segments got %b want %b", e.id, seg, e.seg);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_digit(input int d);
        exp_t e;
        e.seg = seg_n[d];
        e.id  = chk_id++;
        exp_q.push_back(e);
        cyc(1);
    endtask

    task automatic set_sw(input int which, input logic v);
        if (which == 1) sw1 = v;
        else            sw2 = v;
    endtask

    task automatic bounced_press(input int which);
        for (int k = 0; k < 4; k++) begin
            set_sw(which, (k % 2 == 0));
            cyc(3);
        end
        set_sw(which, 1'b1);
        cyc(70);
        for (int k = 0; k < 4; k++) begin
            set_sw(which, (k % 2 != 0));
            cyc(3);
        end
        set_sw(which, 1'b0);
        cyc(70);
    endtask

    task automatic clean_press(input int which);
        set_sw(which, 1'b1);
        cyc(70);
        set_sw(which, 1'b0);
        cyc(70);
    endtask

    initial begin
        rst = 1'b1;
        sw1 = 1'b0;
        sw2 = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        expect_digit(0);

        for (int i = 1; i <= 3; i++) begin
            bounced_press(1);
            expect_digit(i);
        end
        for (int i = 2; i >= 0; i--) begin
            bounced_press(2);
            expect_digit(i);
        end

        for (int i = 1; i <= 9; i++) begin
            clean_press(1);
            expect_digit(i);
        end
        clean_press(1);
        expect_digit(0);
        clean_press(2);
        expect_digit(9);
        clean_press(1);
        expect_digit(0);

        // long hold gives a single increment
        sw1 = 1'b1;
        cyc(250);
        expect_digit(1);
        sw1 = 1'b0;
        cyc(70);
        expect_digit(1);

        // simultaneous presses: increment only
        sw1 = 1'b1;
        sw2 = 1'b1;
        cyc(70);
        expect_digit(2);
        sw1 = 1'b0;
        sw2 = 1'b0;
        cyc(70);
        expect_digit(2);

        // glitches shorter than the debounce window
        sw2 = 1'b1;
        cyc(1);
        sw2 = 1'b0;
        cyc(60);
        expect_digit(2);
        sw2 = 1'b1;
        cyc(DT - 1);
        sw2 = 1'b0;
        cyc(60);
        expect_digit(2);
        sw1 = 1'b1;
        cyc(DT - 1);
        sw1 = 1'b0;
        cyc(60);
        expect_digit(2);

        // reset mid-hold clears at once; held switch counts as new press afterwards
        sw1 = 1'b1;
        cyc(30);
        rst = 1'b1;
        #2;
        expect_digit(0);
        cyc(2);
        rst = 1'b0;
        cyc(DT - 5);
        expect_digit(0);
        cyc(20);
        expect_digit(1);
        sw1 = 1'b0;
        cyc(70);
        expect_digit(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_counter.md
BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_TIME, default 250000 (10 ms at 25 MHz), meaning the number of consecutive stable clock cycles needed to accept a switch level change; legal range >= 1.
REQ-002 SHALL have port i_Clk, input, 1 bit: single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_Switch_1, input, 1 bit: increment push-button, active high, may bounce.
REQ-005 SHALL have port i_Switch_2, input, 1 bit: decrement push-button, active high, may bounce.
REQ-006 SHALL have port o_Segments, output, 7 bits: active-low seven-segment drive, bit6..bit0 = g,f,e,d,c,b,a.

Function
REQ-007 SHALL debounce each switch independently.
- Keep a stable level and a counter per switch.
- Raw input equal to stable level -> clear the counter.
- Raw input different from stable level -> increment the counter.
- When the counter reaches DEBOUNCE_TIME -> the stable level takes the raw value and the counter clears.
- Counter width is $clog2(DEBOUNCE_TIME+1).
REQ-008 SHALL treat any glitch shorter than DEBOUNCE_TIME cycles, on press or release, as no level change.
REQ-009 SHALL generate a one-cycle inc pulse on a 0->1 transition of the debounced switch 1, and a one-cycle dec pulse on a 0->1 transition of the debounced switch 2.
REQ-010 SHALL NOT generate any further pulse while a button stays held, whatever the hold time.
REQ-011 SHALL keep a 4-bit digit register in the range 0..9.
- inc pulse: 9 wraps to 0, otherwise +1.
- dec pulse: 0 wraps to 9, otherwise -1.
REQ-012 SHALL apply only the increment when inc and dec pulses occur in the same cycle.
REQ-013 SHALL register o_Segments from the digit. Active-high patterns (g..a), inverted on output:
- 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
- 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
REQ-014 SHALL make o_Segments reflect a new digit at most DEBOUNCE_TIME+3 cycles after a clean press begins, without the optional synchronizer.
REQ-015 SHALL drive o_Segments to all ones (blank) if the digit register ever holds a value 10..15.

Reset
REQ-016 SHALL, while i_Rst is high, asynchronously clear:
- both stable levels to 0 and both debounce counters to 0;
- the edge-detect history to 0 and the digit to 0;
- o_Segments to 1000000 (displays 0).
REQ-017 SHALL treat a switch held through reset deassertion as a new press, giving one increment or decrement after DEBOUNCE_TIME cycles.

Configuration
REQ-018 SHALL, when macro BUTTON_COUNTER_INPUT_SYNC_EN is defined, pass each switch through a two-flop synchronizer (reset to 0) before debouncing, adding exactly 2 cycles of latency.
REQ-019 SHALL, when BUTTON_COUNTER_INPUT_SYNC_EN is not defined, feed the switches directly to the debouncers; all other behaviour is identical.

Structure
REQ-020 SHALL place the 10-entry segment pattern table, DIGIT_MAX = 9 and the blank pattern in package button_counter_pkg.
REQ-021 SHALL implement the debounce as sub-module debounce_filter (parameter DEBOUNCE_TIME; ports i_Clk, i_Rst, i_Switch, o_Switch), instantiated twice.

Verification (DEBOUNCE_TIME = 50, 40 ns clock)
REQ-022 SHALL check: reset, then 10 idle cycles -> o_Segments = 1000000 (digit 0).
REQ-023 SHALL check: three presses on switch 1, each with 4 toggles 3 cycles apart on press and on release and 70-cycle holds -> digits 1, 2, 3; then three bounced presses on switch 2 -> digits 2, 1, 0.
REQ-024 SHALL check: nine increments from 0 -> 9; one more increment -> 0; one decrement -> 9.
REQ-025 SHALL check: from digit 0, hold switch 1 high for 250 cycles -> digit 1 only.
REQ-026 SHALL check: from digit 1, raise both switches in the same cycle and hold 70 cycles -> digit 2; release -> digit stays 2.
REQ-027 SHALL check: apply a 1-cycle glitch and a 49-cycle pulse on switch 2 -> digit unchanged; assert reset mid-hold -> digit 0 immediately.
